ex_mem_hilo: RTL

- EX/MEM pipeline stage directly downstream of the ALU; captures ALU outputs (Result1, Result2, Equal) plus control, one instruction per cycle.
- Owns the architectural HI/LO registers. Multiply and divide results commit to HI/LO when the instruction retires from this stage.
- Resolves mfhi/mflo, forwarding from an in-flight HI/LO writer held in the stage.
- Supports stall and flush from the hazard unit.

---
 rtl/ex_mem_hilo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_hilo.sv
// EX/MEM pipeline stage owning the architectural HI/LO registers, with mfhi/mflo forwarding.
// Optional retire/stall performance counters are built when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_hilo #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_result1,
    input  logic [DW-1:0] in_result2,
    input  logic          in_equal,
    input  logic [DW-1:0] in_rs_data,
    input  logic [2:0]    in_hilo_op,
    input  logic [RW-1:0] in_rd,
    input  logic          in_regwrite,
    output logic          out_valid,
    output logic [DW-1:0] out_result,
    output logic          out_equal,
    output logic [RW-1:0] out_rd,
    output logic          out_regwrite,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]   retire_cnt,
    output logic [31:0]   stall_cnt
`endif
);

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpWhilo = 3'd1,
        OpMthi  = 3'd2,
        OpMtlo  = 3'd3,
        OpMfhi  = 3'd4,
        OpMflo  = 3'd5
    } hilo_op_e;

    hilo_op_e      op_q, op_d, in_op;
    logic          valid_q, valid_d;
    logic          regwrite_q, regwrite_d;
    logic          equal_q, equal_d;
    logic [RW-1:0] rd_q, rd_d;
    // result_q doubles as the stored Result1: they only differ for mfhi/mflo,
    // which never write HI/LO.
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] result2_q, result2_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0] hi_ret, lo_ret, mf_val;

    always_comb begin
        case (in_hilo_op)
            3'd1:    in_op = OpWhilo;
            3'd2:    in_op = OpMthi;
            3'd3:    in_op = OpMtlo;
            3'd4:    in_op = OpMfhi;
            3'd5:    in_op = OpMflo;
            default: in_op = OpNone;
        endcase
    end

    // HI/LO as they stand after the held instruction retires on this edge.
    always_comb begin
        hi_ret = hi_q;
        lo_ret = lo_q;
        if (valid_q) begin
            case (op_q)
                OpWhilo: begin
                    lo_ret = result_q;
                    hi_ret = result2_q;
                end
                OpMthi:  hi_ret = rs_data_q;
                OpMtlo:  lo_ret = rs_data_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (in_op)
            OpMfhi:  mf_val = hi_ret;
            OpMflo:  mf_val = lo_ret;
            default: mf_val = in_result1;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        equal_d    = equal_q;
        rd_d       = rd_q;
        result_d   = result_q;
        result2_d  = result2_q;
        rs_data_d  = rs_data_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (!stall) begin
            hi_d = hi_ret;
            lo_d = lo_ret;
            if (flush) begin
                op_d       = OpNone;
                valid_d    = 1'b0;
                regwrite_d = 1'b0;
                equal_d    = 1'b0;
                rd_d       = '0;
                result_d   = '0;
                result2_d  = '0;
                rs_data_d  = '0;
            end else begin
                op_d       = in_op;
                valid_d    = in_valid;
                regwrite_d = in_regwrite & in_valid;
                equal_d    = in_equal;
                rd_d       = in_rd;
                result_d   = mf_val;
                result2_d  = in_result2;
                rs_data_d  = in_rs_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= OpNone;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            equal_q    <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            result2_q  <= '0;
            rs_data_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            op_q       <= op_d;
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            equal_q    <= equal_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            result2_q  <= result2_d;
            rs_data_q  <= rs_data_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_result   = result_q;
    assign out_equal    = equal_q;
    assign out_rd       = rd_q;
    assign out_regwrite = regwrite_q & valid_q;
    assign hi           = hi_q;
    assign lo           = lo_q;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q + {31'b0, ~stall & valid_q};
        stall_cnt_d  = stall_cnt_q + {31'b0, stall};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
